// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } fir_state_e;

  // Rounded/saturated result; value is sign-extended to 64 bits.
  typedef struct packed {
    logic               clipped;
    logic signed [63:0] value;
  } rs_t;

  // Ceiling log2, used for pointer and accumulator growth widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = unsigned'(i + 1);
    end
    return r;
  endfunction

  // Round half-up, arithmetic shift right, then clip to a signed out_w range.
  // acc must already be sign-extended to 64 bits from ACC_W.
  function automatic rs_t round_sat(input logic signed [63:0] acc, input int unsigned shift,
                                    input int unsigned out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rs_t                res;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.clipped = 1'b1;
    if (r > hi) begin
      res.value = hi;
    end else if (r < lo) begin
      res.value = lo;
    end else begin
      res.value   = r;
      res.clipped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_tap_buffer.sv
// Circular sample history with one write port and a read port addressed by
// tap offset from the newest sample.
module fir_tap_buffer import fir_pkg::*; #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned TAPS   = 16,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  tap,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [TAPS];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  newest;
  logic [PTR_W-1:0]  idx;

  // Newest entry sits just behind the write pointer; offsets wrap modulo TAPS.
  // Adding TAPS in PTR_W bits is exact because the true result is below TAPS.
  always_comb begin
    newest = (wr_ptr_q == '0) ? PTR_W'(TAPS - 1) : wr_ptr_q - 1'b1;
    if (newest >= tap) idx = newest - tap;
    else               idx = newest - tap + PTR_W'(TAPS);
    rdata = mem_q[idx];
  end

  // Sample storage and write pointer, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < TAPS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q        <= (wr_ptr_q == PTR_W'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/fir_tdm_mac.sv
// Time-multiplexed FIR: one signed MAC per clock over TAPS cycles, with a
// runtime-loadable coefficient bank and rounded, saturated output.
module fir_tdm_mac import fir_pkg::*; #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned COEF_W = 10,
  parameter int unsigned TAPS   = 16,
  parameter int unsigned SHIFT  = 9,
  parameter int unsigned OUT_W  = 9
) (
  input  logic                       clk_100k,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   samp_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       coef_we,
  input  logic [clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_err,
  output logic signed [OUT_W-1:0]    fir_out,
  output logic                       out_valid,
  output logic                       sat
);

  localparam int unsigned PTR_W  = clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + PTR_W;

  fir_state_e               state_q, state_d;
  logic [PTR_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [OUT_W-1:0]  fir_out_q, fir_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;
  logic                     coef_err_q, coef_err_d;
  logic                     accept;
  logic                     coef_ok;
  logic [DATA_W-1:0]        tap_rd;
  logic signed [DATA_W-1:0] samp_rd;
  logic signed [PROD_W-1:0] prod;
  rs_t                      rs;

  fir_tap_buffer #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .PTR_W  (PTR_W)
  ) u_tap_buffer (
    .clk   (clk_100k),
    .rst   (rst),
    .we    (accept),
    .wdata (samp_in),
    .tap   (k_q),
    .rdata (tap_rd)
  );

  // Handshake, coefficient-write qualification and the datapath product.
  // OUT also accepts so a new sample can start in the out_valid edge.
  always_comb begin
    in_ready   = (state_q != StMac);
    accept     = in_valid && in_ready;
    coef_ok    = coef_we && (state_q == StIdle) && (32'(coef_addr) < TAPS);
    coef_err_d = coef_we && !coef_ok;
    samp_rd    = signed'(tap_rd);
    prod       = samp_rd * coef_q[k_q];
    rs         = round_sat(64'(acc_q), SHIFT, OUT_W);
  end

  // Next-state and output logic for the IDLE/MAC/OUT sequencer.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    fir_out_d   = fir_out_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(prod);
        if (k_q == PTR_W'(TAPS - 1)) state_d = StOut;
        else                         k_d     = k_q + 1'b1;
      end
      StOut: begin
        fir_out_d   = rs.value[OUT_W-1:0];
        sat_d       = rs.clipped;
        out_valid_d = 1'b1;
        if (accept) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = StMac;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and coefficient registers with synchronous reset.
  always_ff @(posedge clk_100k) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      acc_q       <= '0;
      fir_out_q   <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      fir_out_q   <= fir_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      coef_err_q  <= coef_err_d;
      if (coef_ok) coef_q[coef_addr] <= coef_data;
    end
  end

  assign fir_out   = fir_out_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Self-checking bench: two 4-tap instances share stimulus (SHIFT=0/OUT_W=16 and
// SHIFT=2/OUT_W=4); a 5-tap instance covers out-of-range coefficient addresses.
module tb_fir_tdm_mac;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [8:0] samp_in;
  logic              in_valid;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic signed [9:0] coef_data;

  logic               in_ready_a, coef_err_a, out_valid_a, sat_a;
  logic signed [15:0] fir_out_a;
  logic               in_ready_b, coef_err_b, out_valid_b, sat_b;
  logic signed [3:0]  fir_out_b;

  logic signed [8:0]  samp_in_c;
  logic               in_valid_c, coef_we_c;
  logic [2:0]         coef_addr_c;
  logic signed [9:0]  coef_data_c;
  logic               in_ready_c, coef_err_c, out_valid_c, sat_c;
  logic signed [15:0] fir_out_c;

  int checks = 0;
  int passes = 0;

  // Reference model: newest-first sample history and the coefficient bank.
  int hist[$];
  int cm[4];

  always #5 clk = ~clk;

  fir_tdm_mac #(.DATA_W(9), .COEF_W(10), .TAPS(4), .SHIFT(0), .OUT_W(16)) dut_a (
    .clk_100k(clk), .rst(rst), .samp_in(samp_in), .in_valid(in_valid), .in_ready(in_ready_a),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err_a),
    .fir_out(fir_out_a), .out_valid(out_valid_a), .sat(sat_a)
  );

  fir_tdm_mac #(.DATA_W(9), .COEF_W(10), .TAPS(4), .SHIFT(2), .OUT_W(4)) dut_b (
    .clk_100k(clk), .rst(rst), .samp_in(samp_in), .in_valid(in_valid), .in_ready(in_ready_b),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err_b),
    .fir_out(fir_out_b), .out_valid(out_valid_b), .sat(sat_b)
  );

  fir_tdm_mac #(.DATA_W(9), .COEF_W(10), .TAPS(5), .SHIFT(0), .OUT_W(16)) dut_c (
    .clk_100k(clk), .rst(rst), .samp_in(samp_in_c), .in_valid(in_valid_c),
    .in_ready(in_ready_c), .coef_we(coef_we_c), .coef_addr(coef_addr_c),
    .coef_data(coef_data_c), .coef_err(coef_err_c), .fir_out(fir_out_c),
    .out_valid(out_valid_c), .sat(sat_c)
  );

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < 4; k++) cm[k] = 0;
  endfunction

  function automatic void model_push(input int s);
    hist.push_front(s);
    if (hist.size() > 4) void'(hist.pop_back());
  endfunction

  function automatic longint model_acc();
    longint s = 0;
    for (int k = 0; k < 4; k++) if (k < hist.size()) s += longint'(hist[k]) * longint'(cm[k]);
    return s;
  endfunction

  // floor((acc + half) / 2^shift), computed with integer division.
  function automatic longint model_round(input longint acc, input int shift);
    longint d, num, q;
    d   = longint'(1) << shift;
    num = acc + ((shift > 0) ? (longint'(1) << (shift - 1)) : 0);
    q   = num / d;
    if (num < 0 && (num % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic longint model_out(input longint acc, input int shift, input int ow);
    longint r, hi;
    r  = model_round(acc, shift);
    hi = (longint'(1) << (ow - 1)) - 1;
    if (r > hi) return hi;
    if (r < -hi - 1) return -hi - 1;
    return r;
  endfunction

  function automatic logic model_clip(input longint acc, input int shift, input int ow);
    return model_round(acc, shift) != model_out(acc, shift, ow);
  endfunction

  function automatic int rand_samp();
    return int'($urandom_range(511)) - 256;
  endfunction

  function automatic int rand_coef();
    return int'($urandom_range(1023)) - 512;
  endfunction

  task automatic write_coef(input int addr, input int data, output logic err);
    coef_we = 1'b1; coef_addr = 2'(addr); coef_data = 10'(data);
    @(posedge clk); #1;
    coef_we = 1'b0;
    err = coef_err_a;
    cm[addr] = data;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3,
                            output logic err);
    logic e0, e1, e2, e3;
    write_coef(0, c0, e0);
    write_coef(1, c1, e1);
    write_coef(2, c2, e2);
    write_coef(3, c3, e3);
    err = e0 | e1 | e2 | e3;
  endtask

  task automatic accept(input int s, input bit we, input int addr, input int data);
    for (int n = 0; n < 20 && in_ready_a !== 1'b1; n++) begin @(posedge clk); #1; end
    samp_in = 9'(s); in_valid = 1'b1;
    coef_we = we; coef_addr = 2'(addr); coef_data = 10'(data);
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    if (we) cm[addr] = data;
    model_push(s);
  endtask

  task automatic wait_out(output int lat, output logic signed [15:0] fa, output logic sa,
                          output logic signed [3:0] fb, output logic sb);
    lat = -1; fa = '0; sa = 1'b0; fb = '0; sb = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid_a === 1'b1) begin
        lat = c; fa = fir_out_a; sa = sat_a; fb = fir_out_b; sb = sat_b;
        break;
      end
    end
  endtask

  task automatic send_sample(input int s, output int lat, output logic signed [15:0] fa,
                             output logic sa, output logic signed [3:0] fb, output logic sb);
    accept(s, 1'b0, 0, 0);
    wait_out(lat, fa, sa, fb, sb);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; samp_in = '0; coef_addr = '0; coef_data = '0;
    in_valid_c = 1'b0; samp_in_c = '0; coef_we_c = 1'b0; coef_addr_c = '0; coef_data_c = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    checks++; if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready_a);
    else passes++;
    checks++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid_a);
    else passes++;
    checks++; if (fir_out_a !== 16'sd0) $display("FAIL reset_fir_out got=%0d want=0", fir_out_a);
    else passes++;
    checks++; if (sat_a !== 1'b0) $display("FAIL reset_sat got=%b want=0", sat_a);
    else passes++;
    checks++; if (coef_err_a !== 1'b0) $display("FAIL reset_coef_err got=%b want=0", coef_err_a);
    else passes++;
    checks++; if (in_ready_c !== 1'b1) $display("FAIL reset_in_ready_c got=%b want=1", in_ready_c);
    else passes++;
  endtask

  task automatic test_impulse();
    int imp[5] = '{1, 2, 3, 4, 0};
    int lat;
    logic signed [15:0] fa;
    logic signed [3:0] fb;
    logic sa, sb, e;
    longint acc;
    load_coefs(1, 2, 3, 4, e);
    checks++; if (e !== 1'b0) $display("FAIL impulse_coef_err got=%b want=0", e); else passes++;
    for (int i = 0; i < 5; i++) begin
      send_sample((i == 0) ? 1 : 0, lat, fa, sa, fb, sb);
      acc = model_acc();
      checks++; if (lat != 5) $display("FAIL impulse_latency[%0d] got=%0d want=5", i, lat);
      else passes++;
      checks++; if (fa !== 16'(imp[i]))
        $display("FAIL impulse_out[%0d] got=%0d want=%0d", i, fa, imp[i]);
      else passes++;
      checks++; if (fb !== 4'(model_out(acc, 2, 4)))
        $display("FAIL impulse_out_b[%0d] got=%0d want=%0d", i, fb, model_out(acc, 2, 4));
      else passes++;
    end
  endtask

  task automatic test_saturation();
    int lat, s;
    logic signed [15:0] fa;
    logic signed [3:0] fb;
    logic sa, sb, e;
    longint acc;
    load_coefs(1, 1, 1, 1, e);
    repeat (4) send_sample(100, lat, fa, sa, fb, sb);
    checks++; if (fb !== 4'sd7 || sb !== 1'b1)
      $display("FAIL sat_const100 got=%0d/%b want=7/1", fb, sb);
    else passes++;
    checks++; if (fa !== 16'sd400) $display("FAIL sat_const100_a got=%0d want=400", fa);
    else passes++;
    load_coefs(2, 0, 0, 0, e);
    send_sample(1, lat, fa, sa, fb, sb);
    checks++; if (fb !== 4'sd1 || sb !== 1'b0)
      $display("FAIL round_half got=%0d/%b want=1/0", fb, sb);
    else passes++;
    load_coefs(-512, -512, -512, -512, e);
    repeat (4) send_sample(-256, lat, fa, sa, fb, sb);
    checks++; if (fb !== 4'sd7 || sb !== 1'b1)
      $display("FAIL sat_pos_b got=%0d/%b want=7/1", fb, sb);
    else passes++;
    checks++; if (fa !== 16'sd32767 || sa !== 1'b1)
      $display("FAIL sat_pos_a got=%0d/%b want=32767/1", fa, sa);
    else passes++;
    for (int r = 0; r < 8; r++) begin
      load_coefs(rand_coef(), rand_coef(), rand_coef(), rand_coef(), e);
      s = rand_samp();
      send_sample(s, lat, fa, sa, fb, sb);
      acc = model_acc();
      checks++; if (fa !== 16'(model_out(acc, 0, 16)) || sa !== model_clip(acc, 0, 16))
        $display("FAIL rand_a[%0d] got=%0d/%b want=%0d/%b", r, fa, sa,
                 model_out(acc, 0, 16), model_clip(acc, 0, 16));
      else passes++;
      checks++; if (fb !== 4'(model_out(acc, 2, 4)) || sb !== model_clip(acc, 2, 4))
        $display("FAIL rand_b[%0d] got=%0d/%b want=%0d/%b", r, fb, sb,
                 model_out(acc, 2, 4), model_clip(acc, 2, 4));
      else passes++;
    end
  endtask

  task automatic test_wrap();
    int ramp[10] = '{1, 3, 6, 10, 14, 18, 22, 26, 30, 34};
    int lat;
    logic signed [15:0] fa;
    logic signed [3:0] fb;
    logic sa, sb, e;
    longint acc;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    load_coefs(1, 1, 1, 1, e);
    for (int i = 0; i < 10; i++) begin
      send_sample(i + 1, lat, fa, sa, fb, sb);
      acc = model_acc();
      checks++; if (fa !== 16'(ramp[i]))
        $display("FAIL wrap_out[%0d] got=%0d want=%0d", i, fa, ramp[i]);
      else passes++;
      checks++; if (fb !== 4'(model_out(acc, 2, 4)))
        $display("FAIL wrap_out_b[%0d] got=%0d want=%0d", i, fb, model_out(acc, 2, 4));
      else passes++;
    end
  endtask

  task automatic test_coef_boundary();
    int lat;
    logic signed [15:0] fa;
    logic signed [3:0] fb;
    logic sa, sb, e;
    longint acc;
    load_coefs(3, -5, 7, 1, e);
    checks++; if (e !== 1'b0) $display("FAIL idle_write_err got=%b want=0", e); else passes++;
    accept(rand_samp(), 1'b0, 0, 0);
    acc = model_acc();
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 10'sd77;
    @(posedge clk); #1;
    coef_we = 1'b0;
    checks++; if (coef_err_a !== 1'b1) $display("FAIL busy_write_err got=%b want=1", coef_err_a);
    else passes++;
    @(posedge clk); #1;
    checks++; if (coef_err_a !== 1'b0) $display("FAIL err_pulse_width got=%b want=0", coef_err_a);
    else passes++;
    wait_out(lat, fa, sa, fb, sb);
    checks++; if (fa !== 16'(model_out(acc, 0, 16)))
      $display("FAIL busy_write_out got=%0d want=%0d", fa, model_out(acc, 0, 16));
    else passes++;
    accept(rand_samp(), 1'b1, 1, -9);
    checks++; if (coef_err_a !== 1'b0)
      $display("FAIL accept_write_err got=%b want=0", coef_err_a);
    else passes++;
    acc = model_acc();
    wait_out(lat, fa, sa, fb, sb);
    checks++; if (fa !== 16'(model_out(acc, 0, 16)) || lat != 5)
      $display("FAIL accept_write_out got=%0d lat=%0d want=%0d lat=5", fa, lat,
               model_out(acc, 0, 16));
    else passes++;
    coef_we_c = 1'b1; coef_addr_c = 3'd5; coef_data_c = 10'sd11;
    @(posedge clk); #1 coef_we_c = 1'b0;
    checks++; if (coef_err_c !== 1'b1) $display("FAIL addr_eq_taps got=%b want=1", coef_err_c);
    else passes++;
    coef_we_c = 1'b1; coef_addr_c = 3'd4;
    @(posedge clk); #1 coef_we_c = 1'b0;
    checks++; if (coef_err_c !== 1'b0) $display("FAIL addr_last_tap got=%b want=0", coef_err_c);
    else passes++;
    coef_we_c = 1'b1; coef_addr_c = 3'd7;
    @(posedge clk); #1 coef_we_c = 1'b0;
    checks++; if (coef_err_c !== 1'b1) $display("FAIL addr_max got=%b want=1", coef_err_c);
    else passes++;
  endtask

  task automatic test_back_to_back();
    longint qa[$], qb[$];
    longint ea, eb, acc;
    int last = -1, run = 0, s, nacc = 0;
    logic rdy, e;
    load_coefs(rand_coef(), rand_coef(), rand_coef(), rand_coef(), e);
    s = rand_samp(); samp_in = 9'(s); in_valid = 1'b1;
    for (int cyc = 0; cyc < 75; cyc++) begin
      if (cyc == 60) in_valid = 1'b0;
      rdy = in_ready_a;
      @(posedge clk); #1;
      if (rdy === 1'b1 && in_valid) begin
        if (run > 0) begin
          checks++; if (run != 4) $display("FAIL ready_low_run got=%0d want=4", run);
          else passes++;
        end
        model_push(s);
        acc = model_acc();
        qa.push_back(model_out(acc, 0, 16));
        qb.push_back(model_out(acc, 2, 4));
        if (last >= 0) begin
          checks++; if (cyc - last != 5)
            $display("FAIL accept_spacing got=%0d want=5", cyc - last);
          else passes++;
        end
        last = cyc; nacc++; run = 0;
        s = rand_samp(); samp_in = 9'(s);
      end else if (in_valid) begin
        run++;
      end
      if (out_valid_a === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          $display("FAIL b2b_extra_output got=%0d want=none", fir_out_a);
        end else begin
          ea = qa.pop_front(); eb = qb.pop_front();
          if (fir_out_a !== 16'(ea) || fir_out_b !== 4'(eb))
            $display("FAIL b2b_out got=%0d/%0d want=%0d/%0d", fir_out_a, fir_out_b, ea, eb);
          else passes++;
        end
      end
    end
    checks++; if (qa.size() != 0 || nacc < 10)
      $display("FAIL b2b_drain got=%0d pending %0d accepted want=0 pending >=10", qa.size(),
               nacc);
    else passes++;
  endtask

  task automatic test_reset_mid_mac();
    int lat;
    logic signed [15:0] fa;
    logic signed [3:0] fb;
    logic sa, sb, seen;
    accept(rand_samp() | 1, 1'b0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    checks++; if (in_ready_a !== 1'b1) $display("FAIL midmac_ready got=%b want=1", in_ready_a);
    else passes++;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid_a !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midmac_no_output got=%b want=0", seen);
    else passes++;
    send_sample(1, lat, fa, sa, fb, sb);
    checks++; if (fa !== 16'(model_out(model_acc(), 0, 16)) || lat != 5)
      $display("FAIL midmac_next got=%0d lat=%0d want=0 lat=5", fa, lat);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_wrap();
    test_coef_boundary();
    test_back_to_back();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
